// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares one cache request port among NR_PORTS requesters, tags each request with a TID, routes responses back by TID owner.
// Latency: request and response paths are combinational (0 cycles); TID pool, lock and error state update on the clock edge.
// Backpressure: a stalled winner stays locked until mem_gnt_i; no request is issued while the TID pool is full.
// Define CACHE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with port 0 highest.
module cache_req_arbiter #(
    parameter int NR_PORTS   = 3,
    parameter int TID_WIDTH  = 2,
    parameter int ADDR_WIDTH = 34,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NR_PORTS-1:0]            req_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NR_PORTS-1:0]            req_we_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NR_PORTS-1:0]            gnt_o,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic                           mem_we_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    output logic [TID_WIDTH-1:0]           mem_tid_o,
    input  logic                           mem_rvalid_i,
    input  logic [TID_WIDTH-1:0]           mem_rtid_i,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    output logic [NR_PORTS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [TID_WIDTH:0]             outstanding_o,
    output logic                           err_o
);
    localparam int NTID = 1 << TID_WIDTH;
    localparam int PW   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q;
    logic [PW-1:0]         lock_port_q;
    logic [TID_WIDTH-1:0]  lock_tid_q;
    logic [NTID-1:0]       busy_q;
    logic [PW-1:0]         owner_q [NTID];
    logic [TID_WIDTH:0]    outstanding_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] addr_arr  [NR_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NR_PORTS];
    logic [PW-1:0]         arb_port;
    logic [PW-1:0]         sel_port;
    logic [TID_WIDTH-1:0]  free_tid;
    logic [TID_WIDTH-1:0]  sel_tid;
    logic                  free_any;
    logic                  handshake;
    logic                  rsp_hit;

    genvar g;
    for (g = 0; g < NR_PORTS; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lowest-index free TID; a TID freed this cycle is only visible next cycle.
    always_comb begin
        free_tid = '0;
        for (int i = NTID - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_tid = TID_WIDTH'(i);
        end
    end
    assign free_any = ~&busy_q;

`ifdef CACHE_ARB_RR_EN
    logic [PW-1:0] rr_ptr_q;

    always_comb begin
        int  idx;
        logic found;
        arb_port = '0;
        found    = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NR_PORTS) idx = idx - NR_PORTS;
            if (!found && req_i[idx]) begin
                arb_port = PW'(idx);
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        arb_port = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) arb_port = PW'(i);
        end
    end
`endif

    // Once locked, port and TID are frozen so the downstream payload stays stable.
    always_comb begin
        if (state_q == LOCKED) begin
            sel_port  = lock_port_q;
            sel_tid   = lock_tid_q;
            mem_req_o = 1'b1;
        end else begin
            sel_port  = arb_port;
            sel_tid   = free_tid;
            mem_req_o = (|req_i) && free_any;
        end
    end

    assign handshake   = mem_req_o && mem_gnt_i;
    assign mem_addr_o  = mem_req_o ? addr_arr[sel_port]  : '0;
    assign mem_wdata_o = mem_req_o ? wdata_arr[sel_port] : '0;
    assign mem_we_o    = mem_req_o && req_we_i[sel_port];
    assign mem_tid_o   = mem_req_o ? sel_tid : '0;

    always_comb begin
        gnt_o = '0;
        if (handshake) gnt_o[sel_port] = 1'b1;
    end

    assign rsp_hit = mem_rvalid_i && busy_q[mem_rtid_i];

    always_comb begin
        rvalid_o = '0;
        if (rsp_hit) rvalid_o[owner_q[mem_rtid_i]] = 1'b1;
    end

    assign rdata_o       = rsp_hit ? mem_rdata_i : '0;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            lock_port_q   <= '0;
            lock_tid_q    <= '0;
            busy_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < NTID; i++) owner_q[i] <= '0;
`ifdef CACHE_ARB_RR_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q     <= LOCKED;
                        lock_port_q <= arb_port;
                        lock_tid_q  <= free_tid;
                    end
                end
                LOCKED: begin
                    if (mem_gnt_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (rsp_hit) busy_q[mem_rtid_i] <= 1'b0;
            if (handshake) begin
                busy_q[sel_tid]  <= 1'b1;
                owner_q[sel_tid] <= sel_port;
`ifdef CACHE_ARB_RR_EN
                rr_ptr_q <= (sel_port == PW'(NR_PORTS - 1)) ? '0 : sel_port + PW'(1);
`endif
            end

            if (mem_rvalid_i && !busy_q[mem_rtid_i]) err_q <= 1'b1;

            if (handshake && !rsp_hit)
                outstanding_q <= outstanding_q + (TID_WIDTH+1)'(1);
            else if (!handshake && rsp_hit)
                outstanding_q <= outstanding_q - (TID_WIDTH+1)'(1);
        end
    end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: drives at posedge+1, samples at posedge+3.
module tb_cache_req_arbiter;
    logic         clk;
    logic         rst_ni;
    logic [2:0]   req_i;
    logic [101:0] req_addr_i;
    logic [2:0]   req_we_i;
    logic [95:0]  req_wdata_i;
    logic [2:0]   gnt_o;
    logic         mem_req_o;
    logic         mem_gnt_i;
    logic [33:0]  mem_addr_o;
    logic         mem_we_o;
    logic [31:0]  mem_wdata_o;
    logic [1:0]   mem_tid_o;
    logic         mem_rvalid_i;
    logic [1:0]   mem_rtid_i;
    logic [31:0]  mem_rdata_i;
    logic [2:0]   rvalid_o;
    logic [31:0]  rdata_o;
    logic [2:0]   outstanding_o;
    logic         err_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [33:0] A0 = 34'h0_8000_0000;
    localparam logic [33:0] A1 = 34'h1_0000_0040;
    localparam logic [33:0] A2 = 34'h2_0000_0100;

    cache_req_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
        .gnt_o(gnt_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_tid_o(mem_tid_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rtid_i(mem_rtid_i), .mem_rdata_i(mem_rdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++; if (gnt_o !== 3'b000) $display("FAIL reset_gnt got %b exp 000", gnt_o); else pass_cnt++;
        total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req_o); else pass_cnt++;
        total_cnt++; if (rvalid_o !== 3'b000 || rdata_o !== 32'h0) $display("FAIL reset_rsp got %b/%h exp 000/0", rvalid_o, rdata_o); else pass_cnt++;
        total_cnt++; if (mem_tid_o !== 2'd0 || outstanding_o !== 3'd0 || err_o !== 1'b0)
            $display("FAIL reset_state got tid=%0d out=%0d err=%b exp 0/0/0", mem_tid_o, outstanding_o, err_o); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_single_read;
        req_i = 3'b001; req_addr_i[33:0] = A0; mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (gnt_o !== 3'b001 || mem_tid_o !== 2'd0) $display("FAIL read_gnt got %b tid %0d exp 001 tid 0", gnt_o, mem_tid_o); else pass_cnt++;
        total_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== A0) $display("FAIL read_addr got %b %h exp 1 %h", mem_req_o, mem_addr_o, A0); else pass_cnt++;
        next_cycle();
        req_i = 3'b000; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rtid_i = 2'd0; mem_rdata_i = 32'hDEADBEEF;
        #2;
        total_cnt++; if (outstanding_o !== 3'd1) $display("FAIL read_outstanding got %0d exp 1", outstanding_o); else pass_cnt++;
        total_cnt++; if (rvalid_o !== 3'b001 || rdata_o !== 32'hDEADBEEF) $display("FAIL read_rsp got %b %h exp 001 deadbeef", rvalid_o, rdata_o); else pass_cnt++;
        next_cycle();
        mem_rvalid_i = 1'b0;
        #2;
        total_cnt++; if (outstanding_o !== 3'd0 || err_o !== 1'b0) $display("FAIL read_free got out=%0d err=%b exp 0/0", outstanding_o, err_o); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_pool_full;
        req_i = 3'b010; req_addr_i[67:34] = A1; mem_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            total_cnt++; if (gnt_o !== 3'b010 || mem_tid_o !== 2'(i)) $display("FAIL fill_%0d got %b tid %0d exp 010 tid %0d", i, gnt_o, mem_tid_o, i); else pass_cnt++;
            next_cycle();
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rtid_i = 2'd2; mem_rdata_i = 32'h1234_5678;
        #2;
        total_cnt++; if (outstanding_o !== 3'd4 || mem_req_o !== 1'b0) $display("FAIL full_block got out=%0d req=%b exp 4/0", outstanding_o, mem_req_o); else pass_cnt++;
        total_cnt++; if (rvalid_o !== 3'b010 || rdata_o !== 32'h1234_5678) $display("FAIL full_rsp got %b %h exp 010 12345678", rvalid_o, rdata_o); else pass_cnt++;
        next_cycle();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (mem_req_o !== 1'b1 || mem_tid_o !== 2'd2 || gnt_o !== 3'b010)
            $display("FAIL refill got req=%b tid=%0d gnt=%b exp 1/2/010", mem_req_o, mem_tid_o, gnt_o); else pass_cnt++;
        total_cnt++; if (outstanding_o !== 3'd3) $display("FAIL refill_out got %0d exp 3", outstanding_o); else pass_cnt++;
        next_cycle();
        req_i = 3'b000; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            mem_rtid_i = 2'(t);
            #2;
            total_cnt++; if (rvalid_o !== 3'b010) $display("FAIL drain_%0d got %b exp 010", t, rvalid_o); else pass_cnt++;
            next_cycle();
        end
        mem_rvalid_i = 1'b0;
        #2;
        total_cnt++; if (outstanding_o !== 3'd0 || err_o !== 1'b0) $display("FAIL drain_end got out=%0d err=%b exp 0/0", outstanding_o, err_o); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_lock;
        req_i = 3'b100; req_addr_i[101:68] = A2; req_addr_i[33:0] = A0; mem_gnt_i = 1'b0;
        #2;
        total_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== A2 || mem_tid_o !== 2'd0 || gnt_o !== 3'b000)
            $display("FAIL lock_start got req=%b addr=%h tid=%0d gnt=%b exp 1/%h/0/000", mem_req_o, mem_addr_o, mem_tid_o, gnt_o, A2); else pass_cnt++;
        next_cycle();
        req_i = 3'b101;
        for (int c = 1; c < 3; c++) begin
            #2;
            total_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== A2 || mem_tid_o !== 2'd0 || gnt_o !== 3'b000)
                $display("FAIL lock_hold_%0d got req=%b addr=%h tid=%0d gnt=%b exp 1/%h/0/000", c, mem_req_o, mem_addr_o, mem_tid_o, gnt_o, A2); else pass_cnt++;
            next_cycle();
        end
        mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (gnt_o !== 3'b100 || mem_addr_o !== A2 || mem_tid_o !== 2'd0)
            $display("FAIL lock_gnt got gnt=%b addr=%h tid=%0d exp 100/%h/0", gnt_o, mem_addr_o, mem_tid_o, A2); else pass_cnt++;
        next_cycle();
        req_i = 3'b001;
        #2;
        total_cnt++; if (gnt_o !== 3'b001 || mem_tid_o !== 2'd1 || mem_addr_o !== A0)
            $display("FAIL after_lock got gnt=%b tid=%0d addr=%h exp 001/1/%h", gnt_o, mem_tid_o, mem_addr_o, A0); else pass_cnt++;
        next_cycle();
        req_i = 3'b000; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rtid_i = 2'd0;
        #2;
        total_cnt++; if (rvalid_o !== 3'b100) $display("FAIL lock_rsp0 got %b exp 100", rvalid_o); else pass_cnt++;
        next_cycle();
        mem_rtid_i = 2'd1;
        #2;
        total_cnt++; if (rvalid_o !== 3'b001) $display("FAIL lock_rsp1 got %b exp 001", rvalid_o); else pass_cnt++;
        next_cycle();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        req_i = 3'b010; mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (gnt_o !== 3'b010 || mem_tid_o !== 2'd0) $display("FAIL mid_gnt got %b tid %0d exp 010 tid 0", gnt_o, mem_tid_o); else pass_cnt++;
        next_cycle();
        req_i = 3'b100; mem_gnt_i = 1'b0;
        next_cycle();
        #2;
        total_cnt++; if (mem_req_o !== 1'b1 || mem_tid_o !== 2'd1 || outstanding_o !== 3'd1)
            $display("FAIL mid_locked got req=%b tid=%0d out=%0d exp 1/1/1", mem_req_o, mem_tid_o, outstanding_o); else pass_cnt++;
        #1;
        rst_ni = 1'b0; req_i = 3'b000;
        #2;
        total_cnt++; if (mem_req_o !== 1'b0 || mem_tid_o !== 2'd0 || outstanding_o !== 3'd0 || gnt_o !== 3'b000)
            $display("FAIL mid_reset got req=%b tid=%0d out=%0d gnt=%b exp 0/0/0/000", mem_req_o, mem_tid_o, outstanding_o, gnt_o); else pass_cnt++;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        mem_rvalid_i = 1'b1; mem_rtid_i = 2'd0; mem_rdata_i = 32'hCAFE_0000;
        #2;
        total_cnt++; if (rvalid_o !== 3'b000 || rdata_o !== 32'h0 || err_o !== 1'b0)
            $display("FAIL stale_rsp got rv=%b data=%h err=%b exp 000/0/0", rvalid_o, rdata_o, err_o); else pass_cnt++;
        next_cycle();
        mem_rvalid_i = 1'b0;
        #2;
        total_cnt++; if (err_o !== 1'b1 || outstanding_o !== 3'd0) $display("FAIL stale_err got err=%b out=%0d exp 1/0", err_o, outstanding_o); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_arbitration;
        logic [2:0] exp_g [4];
`ifdef CACHE_ARB_RR_EN
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif
        rst_ni = 1'b0;
        #2;
        next_cycle();
        rst_ni = 1'b1;
        #2;
        total_cnt++; if (err_o !== 1'b0) $display("FAIL err_cleared got %b exp 0", err_o); else pass_cnt++;
        next_cycle();
        req_i = 3'b111; req_addr_i = {A2, A1, A0}; mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            total_cnt++; if (gnt_o !== exp_g[k] || mem_tid_o !== 2'(k))
                $display("FAIL arb_%0d got gnt=%b tid=%0d exp %b/%0d", k, gnt_o, mem_tid_o, exp_g[k], k); else pass_cnt++;
            next_cycle();
        end
        req_i = 3'b000; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            mem_rtid_i = 2'(t);
            #2;
            total_cnt++; if (rvalid_o !== exp_g[t]) $display("FAIL arb_rsp_%0d got %b exp %b", t, rvalid_o, exp_g[t]); else pass_cnt++;
            next_cycle();
        end
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_ooo_err;
        req_i = 3'b010; mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (gnt_o !== 3'b010 || mem_tid_o !== 2'd0) $display("FAIL ooo_gnt1 got %b tid %0d exp 010 tid 0", gnt_o, mem_tid_o); else pass_cnt++;
        next_cycle();
        req_i = 3'b100;
        #2;
        total_cnt++; if (gnt_o !== 3'b100 || mem_tid_o !== 2'd1) $display("FAIL ooo_gnt2 got %b tid %0d exp 100 tid 1", gnt_o, mem_tid_o); else pass_cnt++;
        next_cycle();
        req_i = 3'b000; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rtid_i = 2'd1; mem_rdata_i = 32'hAAAA_5555;
        #2;
        total_cnt++; if (rvalid_o !== 3'b100 || rdata_o !== 32'hAAAA_5555) $display("FAIL ooo_rsp1 got %b %h exp 100 aaaa5555", rvalid_o, rdata_o); else pass_cnt++;
        next_cycle();
        mem_rtid_i = 2'd0; mem_rdata_i = 32'hBBBB_0001;
        #2;
        total_cnt++; if (rvalid_o !== 3'b010 || rdata_o !== 32'hBBBB_0001) $display("FAIL ooo_rsp0 got %b %h exp 010 bbbb0001", rvalid_o, rdata_o); else pass_cnt++;
        next_cycle();
        mem_rtid_i = 2'd3;
        #2;
        total_cnt++; if (rvalid_o !== 3'b000 || err_o !== 1'b0) $display("FAIL bad_tid_rsp got rv=%b err=%b exp 000/0", rvalid_o, err_o); else pass_cnt++;
        next_cycle();
        mem_rvalid_i = 1'b0;
        #2;
        total_cnt++; if (err_o !== 1'b1 || outstanding_o !== 3'd0) $display("FAIL bad_tid_err got err=%b out=%0d exp 1/0", err_o, outstanding_o); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_back_to_back;
        req_i = 3'b001; mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (gnt_o !== 3'b001 || mem_tid_o !== 2'd0) $display("FAIL b2b_gnt0 got %b tid %0d exp 001 tid 0", gnt_o, mem_tid_o); else pass_cnt++;
        next_cycle();
        req_i = 3'b010; mem_rvalid_i = 1'b1; mem_rtid_i = 2'd0;
        #2;
        total_cnt++; if (gnt_o !== 3'b010 || mem_tid_o !== 2'd1 || rvalid_o !== 3'b001)
            $display("FAIL b2b_both got gnt=%b tid=%0d rv=%b exp 010/1/001", gnt_o, mem_tid_o, rvalid_o); else pass_cnt++;
        next_cycle();
        req_i = 3'b000; mem_gnt_i = 1'b0; mem_rtid_i = 2'd1;
        #2;
        total_cnt++; if (outstanding_o !== 3'd1 || rvalid_o !== 3'b010) $display("FAIL b2b_net got out=%0d rv=%b exp 1/010", outstanding_o, rvalid_o); else pass_cnt++;
        next_cycle();
        mem_rvalid_i = 1'b0;
        #2;
        total_cnt++; if (outstanding_o !== 3'd0) $display("FAIL b2b_end got %0d exp 0", outstanding_o); else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        rst_ni = 1'b0; req_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rtid_i = '0; mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        test_reset();
        test_single_read();
        test_pool_full();
        test_lock();
        test_reset_mid();
        test_arbitration();
        test_ooo_err();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Shares the single data-cache request port between several requesters (load unit, store unit, page-table walker). Issues each granted request with a transaction ID (TID) drawn from a pool of 2^TID_WIDTH identifiers. Routes each out-of-order response back to the requester that owns that TID. Sits between the load/store/PTW ports and the cache subsystem; the pool size matches the core's memory TID width (2 bits, i.e. 4 outstanding transactions).

## Interface
- NR_PORTS, 3, number of requesters; port 0 is the highest-priority requester
- TID_WIDTH, 2, TID width; pool holds 2^TID_WIDTH entries
- ADDR_WIDTH, 34, physical address width (Sv32)
- DATA_WIDTH, 32, data width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  NR_PORTS  per-port request valid
- req_addr_i  in  NR_PORTS*ADDR_WIDTH  per-port address
- req_we_i  in  NR_PORTS  per-port write enable
- req_wdata_i  in  NR_PORTS*DATA_WIDTH  per-port write data
- gnt_o  out  NR_PORTS  per-port grant; one-hot or zero
- mem_req_o  out  1  downstream request valid
- mem_gnt_i  in  1  downstream grant
- mem_addr_o  out  ADDR_WIDTH  downstream address
- mem_we_o  out  1  downstream write enable
- mem_wdata_o  out  DATA_WIDTH  downstream write data
- mem_tid_o  out  TID_WIDTH  TID attached to the request
- mem_rvalid_i  in  1  response valid
- mem_rtid_i  in  TID_WIDTH  TID of the response
- mem_rdata_i  in  DATA_WIDTH  response data
- rvalid_o  out  NR_PORTS  per-port response valid; one-hot or zero
- rdata_o  out  DATA_WIDTH  response data, shared by all ports
- outstanding_o  out  TID_WIDTH+1  number of busy TIDs
- err_o  out  1  sticky flag: a response arrived with a TID that was not busy

## Operation
- **Requester rules.** A requester holds req_i and its payload stable until it sees gnt_o. Every request, read or write, consumes one TID and receives exactly one response.
- **Per-TID state.** Each TID has a busy bit and an owner field (port index).
- **Arbiter states.**
  - IDLE: no port is locked.
  - LOCKED: a winner port and a reserved TID are held in registers.
- **IDLE behaviour.**
  - mem_req_o is asserted when any req_i is high and at least one TID is free.
  - The winner is chosen by the arbitration policy (see Configuration).
  - The reserved TID is the lowest-index free TID.
  - If mem_gnt_i is high in the same cycle, the transaction completes and the state stays IDLE.
  - If mem_gnt_i is low, the winner and TID are registered and the state moves to LOCKED.
- **LOCKED behaviour.**
  - mem_req_o stays high and the payload comes from the locked port. The locked TID is not re-evaluated.
  - On mem_gnt_i, the state returns to IDLE.
  - mem_req_o never drops before mem_gnt_i is seen.
- **Grant handshake** (mem_req_o && mem_gnt_i):
  - gnt_o[winner] is high for that cycle.
  - The TID becomes busy and its owner is set to the winner.
  - The round-robin pointer is set to winner+1, wrapping at NR_PORTS.
- **Response** (mem_rvalid_i):
  - If mem_rtid_i is busy: rvalid_o[owner] is high, rdata_o = mem_rdata_i, and the TID is freed at the clock edge.
  - If mem_rtid_i is not busy: no rvalid_o is asserted, err_o is set, and the TID state is unchanged.
- **Pool full.** With all TIDs busy, mem_req_o stays low while in IDLE. This cannot occur in LOCKED, because the locked TID is already reserved.
- **Simultaneous grant and response** (different TIDs): both state updates apply.
- **outstanding_o** counts busy TIDs:
  - +1 on a grant.
  - −1 on a valid response.
  - Unchanged when both happen in the same cycle.
- **Reset.** At any time, including mid-transaction, reset returns:
  - state IDLE, all TIDs free, all owners 0, pointer 0;
  - mem_req_o=0, gnt_o=0, rvalid_o=0, rdata_o=0, mem_tid_o=0, outstanding_o=0, err_o=0.
- **Responses to pre-reset TIDs.** A response to a TID issued before reset sets err_o.

## Timing
- The request path is combinational: gnt_o follows mem_gnt_i in the same cycle.
- The response path is combinational: rvalid_o/rdata_o follow mem_rvalid_i in the same cycle.
- A freed TID is allocatable from the next cycle; there is no same-cycle bypass.
- Throughput is one grant per cycle while TIDs are free. Back-to-back grants to the same port are allowed.
- All state updates occur on the rising edge of clk_i.

## Configuration
- CACHE_ARB_RR_EN defined: round-robin arbitration. The search starts at the round-robin pointer and takes the first requesting port in ascending order with wrap.
- CACHE_ARB_RR_EN undefined: fixed priority; the lowest requesting port index wins. The round-robin pointer register is not built.

## Test plan
- **Reset state:** after reset release, all outputs are 0 and outstanding_o=0.
- **Single read:** req_i=3'b001, addr=34'h0_8000_0000, mem_gnt_i=1 → gnt_o=3'b001 and mem_tid_o=0 in the same cycle. Then mem_rvalid_i with rtid=0 and rdata=32'hDEADBEEF → rvalid_o=3'b001 and rdata_o=32'hDEADBEEF.
- **Pool full:** 4 grants with no responses → outstanding_o=4 and mem_req_o=0 while req_i≠0. A response for TID 2 → mem_req_o rises next cycle with mem_tid_o=2.
- **Lock:** with mem_gnt_i=0 for 3 cycles, a higher-priority port raising req_i does not change mem_addr_o or mem_tid_o. Grant on cycle 4 goes to the original port.
- **Arbitration with all 3 ports requesting and mem_gnt_i=1:**
  - CACHE_ARB_RR_EN defined: grants follow the order 0,1,2,0.
  - CACHE_ARB_RR_EN undefined: port 0 wins every cycle.
- **Out-of-order responses and error:** ports 1 and 2 hold TIDs 0 and 1. Responses arrive as TID 1 then TID 0 → rvalid_o=3'b100 then 3'b010. A response with TID 3 while free → err_o=1 and rvalid_o=0.
